booth_share_ctrl: RTL and testbench

- Time-shares one `booth` sequential 8x8 signed multiplier between two independent requesters (port 0, port 1).
- Round-robin arbitration; sequences the multiplier's start/valid handshake; returns each 16-bit product to its owner with a one-cycle done pulse.
- Watchdog flags a multiplier that never completes.
- Sits between client logic and the `booth` instance; it is the only driver of `booth` start/in1/in2.

---
 rtl/booth_share_pkg.sv | 28 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/booth_share_ctrl.sv | 137 +++++++++++++
 tb/tb_booth_share_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_share_pkg.sv
// Shared types and sizing helpers for the booth multiplier share controller.
// Holds the FSM state encoding, default widths and the counter-width function.
package booth_share_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        DONE
    } state_t;

    localparam int DEF_W  = 8;
    localparam int DEF_PW = 2 * DEF_W;

    // Bits needed to count up to max(settle, timeout).
    function automatic int cnt_width(input int settle, input int timeout);
        int m;
        int w;
        m = (settle > timeout) ? settle : timeout;
        w = 1;
        while ((1 << w) < (m + 1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports: req0/req1 requests, ptr preferred port; grant_valid any request, grant_idx winner.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = 1'b0;
        unique case ({req1, req0})
            2'b11:   grant_idx = ptr;
            2'b10:   grant_idx = 1'b1;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/booth_share_ctrl.sv
// Time-shares one sequential booth multiplier between two requesters.
// Ports: req/a/b in and gnt/done/res out per port; mul_* drive/observe booth; busy, err status.
module booth_share_ctrl
    import booth_share_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    output logic             gnt0,
    output logic             done0,
    output logic [2*W-1:0]   res0,
    input  logic             req1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             gnt1,
    output logic             done1,
    output logic [2*W-1:0]   res1,
    output logic             mul_start,
    output logic [W-1:0]     mul_in1,
    output logic [W-1:0]     mul_in2,
    input  logic             mul_valid,
    input  logic [2*W-1:0]   mul_out,
    output logic             busy,
    output logic             err
);

    localparam int PW = (W == DEF_W) ? DEF_PW : 2 * W;
    localparam int CW = cnt_width(SETTLE, TIMEOUT);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    state_t        state;
    logic          owner;
    logic          ptr;
    logic [CW-1:0] cnt;
    logic          grant_valid;
    logic          grant_idx;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            ptr       <= 1'b0;
            cnt       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            res0      <= '0;
            res1      <= '0;
            mul_start <= 1'b0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            mul_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_idx;
                        mul_in1   <= grant_idx ? a1 : a0;
                        mul_in2   <= grant_idx ? b1 : b0;
                        gnt0      <= ~grant_idx;
                        gnt1      <= grant_idx;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= booth_share_pkg::SETTLE;
                end
                booth_share_pkg::SETTLE: begin
                    // booth may still show valid from its previous op here
                    if (cnt == SET_LAST) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // a valid on the final timeout cycle still counts
                    if (mul_valid) begin
                        if (owner) res1 <= mul_out[PW-1:0];
                        else       res0 <= mul_out[PW-1:0];
                        done0 <= ~owner;
                        done1 <= owner;
                        cnt   <= '0;
                        state <= DONE;
                    end else if (cnt == TO_LAST) begin
                        if (owner) res1 <= '0;
                        else       res0 <= '0;
                        done0 <= ~owner;
                        done1 <= owner;
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ptr   <= ~owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_share_ctrl.sv
// Directed bench for booth_share_ctrl with a behavioural booth stub.
// Covers single ops, arbitration order, fairness, timeout and mid-op reset.
module tb_booth_share_ctrl;

    localparam int W       = 8;
    localparam int PW      = 16;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          gnt0, gnt1, done0, done1;
    logic [PW-1:0] res0, res1;
    logic          mul_start;
    logic [W-1:0]  mul_in1, mul_in2;
    logic          mul_valid = 1'b0;
    logic [PW-1:0] mul_out = '0;
    logic          busy, err;

    booth_share_ctrl #(
        .W       (W),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .gnt0      (gnt0),
        .done0     (done0),
        .res0      (res0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt1      (gnt1),
        .done1     (done1),
        .res1      (res1),
        .mul_start (mul_start),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_valid (mul_valid),
        .mul_out   (mul_out),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // booth stub: mode 0 = product after LAT cycles, valid held until next start;
    // mode 1 = valid already high, held through SETTLE, then never again.
    int            stub_mode = 0;
    bit            stale_used = 0;
    int            lat = 0;
    int            hold = 0;
    logic [PW-1:0] m_p;

    always @(negedge clk) begin
        if (stub_mode == 0) stale_used = 0;
        if (mul_start) begin
            m_p = 16'(int'($signed(mul_in1)) * int'($signed(mul_in2)));
            if (stub_mode == 0) begin
                mul_valid = 1'b0;
                lat = LAT;
            end else begin
                hold = SETTLE + 1;
                stale_used = 1;
            end
        end else if (stub_mode == 1 && !stale_used) begin
            mul_valid = 1'b1;
        end else if (stub_mode == 0 && lat > 0) begin
            lat--;
            if (lat == 0) begin
                mul_valid = 1'b1;
                mul_out = m_p;
            end
        end else if (stub_mode == 1 && hold > 0) begin
            hold--;
            if (hold == 0) mul_valid = 1'b0;
        end
    end

    // monitor
    int          nstart = 0;
    int          overlap = 0;
    int          bad_sg = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    bit          op_open = 0;
    logic [7:0]  st_in1, st_in2;
    int          gq[$];
    logic [17:0] dq[$];

    always @(negedge clk) begin
        if (rst) begin
            op_open = 0;
        end else begin
            if (((gnt0 | gnt1) !== mul_start) || (gnt0 & gnt1)) bad_sg++;
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
            if (mul_start) begin
                nstart++;
                start_cyc = cyc;
                st_in1 = mul_in1;
                st_in2 = mul_in2;
                if (op_open) overlap++;
                op_open = 1;
            end
            if (done0 | done1) begin
                op_open = 0;
                done_cyc = cyc;
                dq.push_back({done1, err, done1 ? res1 : res0});
            end
        end
    end

    task automatic wait_gnt(input int port, input string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if ((port == 0 && gnt0) || (port == 1 && gnt1)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (done0 | done1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic op(input int port, input logic [7:0] a, input logic [7:0] b, input string tag);
        bit ok;
        if (port == 0) begin
            a0 = a; b0 = b; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; req1 = 1'b1;
        end
        wait_gnt(port, tag, ok);
        req0 = 1'b0;
        req1 = 1'b0;
        if (ok) wait_done(tag, ok);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok0, ok1;
        int base, db, n0, ov0, seq, gsz;
        logic [17:0] d0, d1;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flags", {gnt0, gnt1, done0, done1, busy, mul_start, err}, 0);
        chk("rst_res", {res0, res1}, 0);
        chk("rst_opnd", {mul_in1, mul_in2}, 0);
        rst = 1'b0;

        // port 0 alone: 4 x 5
        n0 = nstart;
        op(0, 8'd4, 8'd5, "p0");
        chk("p0_done", {done0, done1}, 2'b10);
        chk("p0_res", res0, 20);
        chk("p0_err", err, 0);
        chk("p0_nstart", nstart - n0, 1);
        chk("p0_opnd", {st_in1, st_in2}, 16'h0405);
        chk("p0_lat", done_cyc - start_cyc, LAT + 1);
        @(negedge clk);
        #1;
        chk("p0_idle", {busy, done0}, 0);

        // both ports in the same cycle, fresh pointer
        do_reset();
        base = gq.size();
        db = dq.size();
        a0 = 8'd6; b0 = 8'd10;
        a1 = 8'hF6; b1 = 8'd20;
        req0 = 1'b1;
        req1 = 1'b1;
        fork
            begin wait_gnt(0, "b0", ok0); req0 = 1'b0; end
            begin wait_gnt(1, "b1", ok1); req1 = 1'b0; end
        join
        for (int i = 0; i < 60; i++) begin
            if (dq.size() >= db + 2) break;
            @(negedge clk);
            #1;
        end
        chk("both_ndone", dq.size() - db, 2);
        chk("both_order", {(gq.size() > base) ? gq[base] : 9, (gq.size() > base + 1) ? gq[base + 1] : 9}, {32'd0, 32'd1});
        d0 = (dq.size() > db) ? dq[db] : '1;
        d1 = (dq.size() > db + 1) ? dq[db + 1] : '1;
        chk("both_first", d0, {2'b00, 16'd60});
        chk("both_second", d1, {2'b10, 16'hFF38});
        chk("both_res0_kept", res0, 60);

        // fairness over six back-to-back ops
        base = gq.size();
        ov0 = overlap;
        a0 = 8'd2; b0 = 8'd3;
        a1 = 8'hFF; b1 = 8'd5;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (gq.size() >= base + 6) break;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        gsz = gq.size() - base;
        chk("rr_count", gsz, 6);
        seq = 0;
        for (int i = 0; i < 6; i++) begin
            seq = seq * 2 + ((gq.size() > base + i) ? gq[base + i] : 1);
        end
        chk("rr_seq", seq, 6'b010101);
        chk("rr_overlap", overlap - ov0, 0);
        chk("rr_res", {res0, res1}, {16'd6, 16'hFFFB});

        // stale valid during SETTLE, then no valid: timeout
        stub_mode = 1;
        repeat (2) @(negedge clk);
        #1;
        op(0, 8'd9, 8'd9, "to");
        chk("to_done", {done0, done1}, 2'b10);
        chk("to_err", err, 1);
        chk("to_res", res0, 0);
        chk("to_lat", done_cyc - start_cyc, 1 + SETTLE + TIMEOUT);
        @(negedge clk);
        #1;
        chk("to_err_pulse", {err, busy}, 0);
        stub_mode = 0;
        repeat (SETTLE + 2) @(negedge clk);

        // reset two cycles after a port 1 start
        db = dq.size();
        a1 = 8'd3; b1 = 8'd7;
        req1 = 1'b1;
        wait_gnt(1, "mr", ok1);
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_flags", {gnt0, gnt1, done0, done1, busy, mul_start, err}, 0);
        chk("mr_res", {res0, res1}, 0);
        chk("mr_opnd", {mul_in1, mul_in2}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("mr_no_done", dq.size() - db, 0);
        chk("mr_idle", busy, 0);
        op(0, 8'd2, 8'd2, "mr2");
        chk("mr2_done", {done0, done1, err}, 3'b100);
        chk("mr2_res", res0, 4);

        chk("start_gnt", bad_sg, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
